// File: rtl/rv_mem_sequential_if.sv
// Request/response bundle for rv_mem_sequential: a valid/ready request stream in
// and a valid/ready read-data stream out.
interface rv_mem_sequential_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/rv_mem_sequential.sv
// Single-port synchronous memory terminating a request stream; reads return
// in order through a 3-entry response FIFO, writes produce no response.
module rv_mem_sequential #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                rst,
  rv_mem_sequential_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] fifo [3];
  logic                  inflight;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            count;
  logic [2:0]            occupancy;
  logic                  req_fire;
  logic                  read_fire;
  logic                  write_fire;
  logic                  pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Counting the in-flight read as occupied guarantees it a FIFO slot, so
  // ready never needs to look at resp_ready.
  always_comb begin
    occupancy     = {1'b0, count} + {2'b00, inflight};
    bus.req_ready = rst && (occupancy < 3'd3);
    req_fire      = bus.req_valid && bus.req_ready;
    read_fire     = req_fire && bus.req_op;
    write_fire    = req_fire && !bus.req_op;
    bus.resp_valid = (count != 2'd0);
    bus.resp_data  = fifo[rd_ptr];
    pop           = bus.resp_valid && bus.resp_ready;
  end

  always_ff @(posedge clk) begin
    if (write_fire) mem[bus.req_addr] <= bus.req_data;
    if (read_fire)  rd_word <= mem[bus.req_addr];
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo[wr_ptr] <= rd_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= read_fire;
      if (inflight) wr_ptr <= next_ptr(wr_ptr);
      if (pop)      rd_ptr <= next_ptr(rd_ptr);
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule
